// File: rtl/core_pkg.sv
// Shared core types: load/store function codes, LSU FSM states and access-width helpers.
package core_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } load_store_func_code;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT
  } lsu_state_e;

  function automatic logic is_half(input load_store_func_code op);
    return (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
  endfunction

  function automatic logic is_word(input load_store_func_code op);
    return (op == LSU_LW) || (op == LSU_SW);
  endfunction

  function automatic logic is_unsigned(input load_store_func_code op);
    return (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

  function automatic logic is_store(input load_store_func_code op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  function automatic logic is_misaligned(input load_store_func_code op, input logic [1:0] off);
    return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and memory (slave): req/gnt request, rvalid response.
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    data_req_op;
  logic [ADDR_WIDTH-1:0]   data_addr_op;
  logic                    data_we_op;
  logic [DATA_WIDTH/8-1:0] data_be_op;
  logic [DATA_WIDTH-1:0]   data_wdata_op;
  logic                    data_gnt_ip;
  logic                    data_rvalid_ip;
  logic [DATA_WIDTH-1:0]   data_rdata_ip;

  modport master (
    output data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
    input  data_gnt_ip, data_rvalid_ip, data_rdata_ip
  );

  modport slave (
    input  data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
    output data_gnt_ip, data_rvalid_ip, data_rdata_ip
  );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a loaded word and sign- or zero-extends it.
module lsu_load_align
  import core_pkg::*;
(
  input  load_store_func_code operator_i,
  input  logic [1:0]          offset_i,
  input  logic [31:0]         rdata_i,
  output logic [31:0]         data_o
);

  logic [31:0] shifted;
  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    if (is_word(operator_i)) begin
      data_o = rdata_i;
    end else if (is_half(operator_i)) begin
      data_o = is_unsigned(operator_i) ? {16'h0000, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
    end else begin
      data_o = is_unsigned(operator_i) ? {24'h000000, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: runs one req/gnt/rvalid data-memory transaction at a time for decode.
module load_store_unit
  import core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en_lsu_ip,
  input  load_store_func_code   lsu_operator_ip,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_ip,
  input  logic [31:0]           lsu_wdata_ip,
  load_store_unit_if.master     data_bus,
  output logic [31:0]           mem_data_op,
  output logic                  mem_data_valid_op,
  output logic                  lsu_busy_op,
  output logic                  misaligned_op
);

  lsu_state_e              state_q, state_d;
  load_store_func_code     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [31:0]             mem_data_q, mem_data_d;
  logic                    valid_q, valid_d;
  logic                    misaligned_q, misaligned_d;
  logic [31:0]             load_data;

  lsu_load_align u_load_align (
    .operator_i (op_q),
    .offset_i   (addr_q[1:0]),
    .rdata_i    (data_bus.data_rdata_ip),
    .data_o     (load_data)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    mem_data_d   = mem_data_q;
    valid_d      = 1'b0;
    misaligned_d = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        if (en_lsu_ip) begin
          if (is_misaligned(lsu_operator_ip, lsu_addr_ip[1:0])) begin
            misaligned_d = 1'b1;
          end else begin
            op_d    = lsu_operator_ip;
            addr_d  = lsu_addr_ip;
            state_d = LSU_REQ;
            // Replicate store data so every lane carries it; be selects the live lanes.
            if (is_word(lsu_operator_ip)) begin
              be_d    = 4'b1111;
              wdata_d = lsu_wdata_ip;
            end else if (is_half(lsu_operator_ip)) begin
              be_d    = 4'b0011 << lsu_addr_ip[1:0];
              wdata_d = {2{lsu_wdata_ip[15:0]}};
            end else begin
              be_d    = 4'b0001 << lsu_addr_ip[1:0];
              wdata_d = {4{lsu_wdata_ip[7:0]}};
            end
          end
        end
      end
      LSU_REQ: begin
        if (data_bus.data_gnt_ip) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (data_bus.data_rvalid_ip) begin
          state_d = LSU_IDLE;
          if (!is_store(op_q)) begin
            mem_data_d = load_data;
            valid_d    = 1'b1;
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LSU_IDLE;
      op_q         <= LSU_LB;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      mem_data_q   <= '0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      mem_data_q   <= mem_data_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Reset masks req combinationally so an in-flight request drops at once.
  assign data_bus.data_req_op   = (state_q == LSU_REQ) && !reset;
  assign data_bus.data_addr_op  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign data_bus.data_we_op    = is_store(op_q);
  assign data_bus.data_be_op    = be_q;
  assign data_bus.data_wdata_op = wdata_q;

  assign mem_data_op       = mem_data_q;
  assign mem_data_valid_op = valid_q;
  assign lsu_busy_op       = (state_q != LSU_IDLE);
  assign misaligned_op     = misaligned_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory stage directly downstream of the decode stage. It takes the LSU enable, the load/store function code and the store data from decode, plus the effective address from the ALU, and runs one data-memory transaction at a time over a req/gnt/rvalid bus. Load results go back to decode, sign- or zero-extended, with a one-cycle valid pulse for register write-back.

Parameters:
ADDR_WIDTH, 32, width of the effective address and the memory address bus
DATA_WIDTH, 32, data word width; only 32 is supported, and byte enables are DATA_WIDTH/8

Ports:
clock  input  1  core clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
en_lsu_ip  input  1  decode requests a load/store this cycle
lsu_operator_ip  input  load_store_func_code  LB/LH/LW/LBU/LHU/SB/SH/SW
lsu_addr_ip  input  ADDR_WIDTH  effective address (ALU result)
lsu_wdata_ip  input  32  store data (rs2 value from decode)
data_req_op  output  1  memory request
data_addr_op  output  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
data_we_op  output  1  1 = store, 0 = load
data_be_op  output  4  byte enables
data_wdata_op  output  32  store data shifted into the addressed lanes
data_gnt_ip  input  1  memory accepts the request
data_rvalid_ip  input  1  response valid (load data or store ack)
data_rdata_ip  input  32  load data word
mem_data_op  output  32  extended load result to decode
mem_data_valid_op  output  1  one-cycle pulse: mem_data_op valid for write-back
lsu_busy_op  output  1  transaction in flight; decode must hold
misaligned_op  output  1  one-cycle pulse: request rejected as misaligned

Behaviour:
- Reset: all outputs 0; mem_data_op = 0; FSM = IDLE; latched operation cleared.
- FSM states are IDLE, REQ and WAIT.
- IDLE, when en_lsu_ip=1 and the access is aligned:
  - latch operator, address and shifted store data / byte enables;
  - next state REQ.
- IDLE, when en_lsu_ip=1 and the access is misaligned (H: addr[0]≠0; W: addr[1:0]≠0):
  - misaligned_op pulses next cycle;
  - no memory request is made; stay in IDLE.
- REQ:
  - data_req_op=1; addr, we, be and wdata are held stable until data_gnt_ip=1;
  - on grant, next state WAIT and data_req_op drops the following cycle.
  - Gnt latency is unbounded; no timeout.
- WAIT:
  - data_req_op=0; wait for data_rvalid_ip.
  - Load: the extended result is registered into mem_data_op and mem_data_valid_op pulses for 1 cycle after rvalid.
  - Store: no mem_data_valid_op.
  - In both cases return to IDLE.
  - rvalid in the same cycle as gnt is illegal on this bus; it is not handled.
- lsu_busy_op = (state≠IDLE). en_lsu_ip while busy is ignored and is not queued.
- Minimum aligned load latency: en at cycle 0 → req at 1 → gnt at 1 → rvalid at 2 → mem_data_valid_op at 3.
- Byte enables:
  - B: 1<<addr[1:0];
  - H: 4'b0011<<addr[1:0];
  - W: 4'b1111.
- Store data:
  - B: replicated byte placed in lane addr[1:0];
  - H: halfword in lanes addr[1:0]..+1;
  - W: unchanged.
  - Lanes outside be are don't-care; drive the replicated value.
- Load extraction:
  - byte/half selected by addr[1:0];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_data_op holds its last value between pulses.
- Reset asserted in REQ/WAIT: return to IDLE next edge and drop req immediately. A late rvalid arriving in IDLE is ignored and produces no valid pulse.

Decomposition:
- CORE_PKG holds load_store_func_code (existing) and a new lsu_state_e {LSU_IDLE, LSU_REQ, LSU_WAIT}.
- Width helper functions is_half/is_word/is_unsigned go in CORE_PKG.
- One sub-module, lsu_load_align: combinational; inputs operator, addr[1:0], rdata; output 32-bit extended data.

Test Plan:
1. SW addr 0x1000, data 0xDEADBEEF, gnt same cycle as req, rvalid next → addr 0x1000, we=1, be=1111, wdata 0xDEADBEEF; no valid pulse; busy returns to 0.
2. SB addr 0x1003, data 0x000000AB → addr 0x1000, be=1000, wdata[31:24]=0xAB.
3. LB addr 0x2001, rdata 0x123480FF → mem_data_op 0xFFFFFF80, valid pulse of 1 cycle. LBU at the same address → 0x00000080.
4. LH addr 0x2002, rdata 0x80010000 → 0xFFFF8001. LHU → 0x00008001.
5. LW addr 0x2002 → misaligned_op pulse, data_req_op never asserts, busy stays 0.
6. Two further bus cases:
   - LW with gnt held low for 3 cycles → req and addr stable all 3 cycles, a second en during busy is ignored, and exactly one valid pulse occurs.
   - reset in WAIT, then rvalid → no valid pulse, FSM IDLE.
